// File: rtl/logic_unit_seq_if.sv
// Handshake bundle for the slice-serial logic unit: operand request in, result out.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface logic_unit_seq_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             zero;
   logic             busy;

   // Requester / result consumer side
   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, out, zero, busy
   );

   // Logic unit side
   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, out, zero, busy
   );
endinterface

// File: rtl/logic_unit_seq.sv
// Slice-serial bitwise logic unit: latches a/b/op, evaluates SLICE bits per cycle LSB first.
// Latency: result valid N=WIDTH/SLICE cycles after acceptance; one op per N+2 cycles at best.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module logic_unit_seq #(
   parameter int WIDTH = 32,
   parameter int SLICE = 4
) (
   input  logic          clk,
   input  logic          rst,
   logic_unit_seq_if.slave bus
);
   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       op_q;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_nxt;
   logic             zero_q;
   logic             last;
   logic [SLICE-1:0] sa;
   logic [SLICE-1:0] sb;
   logic [SLICE-1:0] sr;
   int               base;

   assign last     = (cnt == CW'(N - 1));
   assign bus.out  = out_q;
   assign bus.zero = zero_q;

   // Evaluate the current slice and build the result as it will look after this edge
   always_comb begin
      base = int'(cnt) * SLICE;
      sa   = a_q[base +: SLICE];
      sb   = b_q[base +: SLICE];
      case (op_q)
         3'b000:  sr = sa & sb;
         3'b001:  sr = sa | sb;
         3'b010:  sr = sa ^ sb;
         3'b011:  sr = ~(sa | sb);
         3'b100:  sr = ~(sa ^ sb);
         3'b101:  sr = ~(sa & sb);
         3'b110:  sr = sa & ~sb;
         default: sr = ~sa;
      endcase
      out_nxt = out_q;
      out_nxt[base +: SLICE] = sr;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and state-decoded handshake outputs
   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.busy      = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = BUSY;
         end
         BUSY: begin
            bus.busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, slice write-back and zero flag; operands are only sampled on acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         cnt    <= '0;
         out_q  <= '0;
         zero_q <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q   <= bus.a;
                  b_q   <= bus.b;
                  op_q  <= bus.op;
                  out_q <= '0;
                  cnt   <= '0;
               end
            end
            BUSY: begin
               out_q <= out_nxt;
               if (last) begin
                  cnt    <= '0;
                  zero_q <= (out_nxt == '0);
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule
